// File: rtl/reset_gen_if.sv
// PLL-facing signals of the board reset sequencer: lock flag in, active-low resets out.
interface reset_gen_if;
  logic PllLocked;
  logic PllRESETn;
  logic FgRESETn;

  modport master (output PllLocked, input PllRESETn, input FgRESETn);
  modport slave  (input PllLocked, output PllRESETn, output FgRESETn);
endinterface

// File: rtl/reset_gen.sv
// Board-level reset sequencer: holds the PLL in reset, qualifies a stable lock, then
// releases the function-generator reset; recovers from lock loss and lock timeout.
module reset_gen #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 32,
  parameter int FG_DELAY_CYCLES    = 64,
  parameter int LOCK_TIMEOUT       = 4096,
  parameter int CNT_W              = 16
) (
  input  logic        CLK,
  input  logic        ExtRESET,
  reset_gen_if.slave  pll
);

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    DELAY     = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(FG_DELAY_CYCLES - 1);

  logic [1:0]       rst_sync;
  logic             rst_i;
  logic [1:0]       lock_sync;
  logic             lock_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pll_rstn_q;
  logic             fg_rstn_q;

  // Reset synchronizer: asserts with ExtRESET, releases on the 2nd CLK rise after it falls.
  always_ff @(posedge CLK or posedge ExtRESET) begin
    if (ExtRESET) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_i = ~rst_sync[1];

  // Lock synchronizer stage
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) lock_sync <= 2'b00;
    else       lock_sync <= {lock_sync[0], pll.PllLocked};
  end

  assign lock_s = lock_sync[1];

  // Sequencer state stage; outputs are decoded from the next state so they leave flops.
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      state      <= RST_PLL;
      cnt        <= '0;
      pll_rstn_q <= 1'b0;
      fg_rstn_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pll_rstn_q <= (state_nxt != RST_PLL);
      fg_rstn_q  <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      RST_PLL: begin
        if (cnt == PLL_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          state_nxt = RST_PLL;
          cnt_nxt   = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STB_LAST) begin
          state_nxt = DELAY;
          cnt_nxt   = '0;
        end
      end
      DELAY: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == DLY_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) state_nxt = WAIT_LOCK;
      end
      default: begin
        state_nxt = RST_PLL;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign pll.PllRESETn = pll_rstn_q;
  assign pll.FgRESETn  = fg_rstn_q;

endmodule

// File: tb/tb_reset_gen.sv
// Bench for reset_gen: directed sequences plus random lock/reset activity, checked every
// cycle against a lock-qualification reference model.
module tb_reset_gen;

  localparam int PLL_RST  = 16;
  localparam int STB      = 32;
  localparam int DLY      = 64;
  localparam int TMO      = 4096;
  localparam int QUAL_LEN = STB + DLY;

  localparam int PH_PLL  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_QUAL = 2;

  logic clk_tb = 1'b0;
  logic ext_reset = 1'b1;

  reset_gen_if pll_bus();

  reset_gen #(
    .PLL_RST_CYCLES    (PLL_RST),
    .LOCK_STABLE_CYCLES(STB),
    .FG_DELAY_CYCLES   (DLY),
    .LOCK_TIMEOUT      (TMO),
    .CNT_W             (16)
  ) dut (
    .CLK     (clk_tb),
    .ExtRESET(ext_reset),
    .pll     (pll_bus)
  );

  always #5 clk_tb = ~clk_tb;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Reference model: internal reset age, lock sync pipe, phase and consecutive-lock streak
  int m_sync, m_lk1, m_lk2, m_phase, m_n, m_streak;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_lk1 = 0; m_lk2 = 0;
    m_phase = PH_PLL; m_n = 0; m_streak = 0;
  endtask

  task automatic model_edge(input bit ext, input bit lk);
    bit ri;
    bit ls;
    if (ext) begin
      model_reset();
      return;
    end
    ri = (m_sync < 2);
    ls = (m_lk2 != 0);
    if (ri) begin
      m_lk1 = 0; m_lk2 = 0;
    end else begin
      m_lk2 = m_lk1; m_lk1 = int'(lk);
    end
    if (m_sync < 2) m_sync++;
    if (!ri) begin
      case (m_phase)
        PH_PLL: begin
          m_n++;
          if (m_n == PLL_RST) begin m_phase = PH_WAIT; m_n = 0; end
        end
        PH_WAIT: begin
          if (ls) begin
            m_phase = PH_QUAL; m_streak = 0;
          end else begin
            m_n++;
            if (m_n == TMO) begin m_phase = PH_PLL; m_n = 0; end
          end
        end
        default: begin
          if (!ls) begin
            m_phase = PH_WAIT; m_n = 0;
          end else if (m_streak < 100000) begin
            m_streak++;
          end
        end
      endcase
    end
  endtask

  function automatic logic exp_pll();
    return m_phase != PH_PLL;
  endfunction

  function automatic logic exp_fg();
    return (m_phase == PH_QUAL) && (m_streak >= QUAL_LEN);
  endfunction

  task automatic cycle(input bit ext, input bit lk);
    bit rise;
    @(negedge clk_tb);
    rise = ext && !ext_reset;
    ext_reset = ext;
    pll_bus.PllLocked = lk;
    if (ext) model_reset();
    if (rise) begin
      #1;
      chk("async_pll", {31'd0, pll_bus.PllRESETn}, 32'd0);
      chk("async_fg",  {31'd0, pll_bus.FgRESETn},  32'd0);
    end
    @(posedge clk_tb);
    model_edge(ext, lk);
    #1;
    cyc++;
    chk("pll", {31'd0, pll_bus.PllRESETn}, {31'd0, exp_pll()});
    chk("fg",  {31'd0, pll_bus.FgRESETn},  {31'd0, exp_fg()});
    if (pll_bus.FgRESETn && !pll_bus.PllRESETn) chk("fg_without_pll", 32'd1, 32'd0);
  endtask

  initial begin
    int pll_rise, fg_rise, drop, rec, fg_seen, lows, fall1, fall2;
    logic prev_pll;
    bit lk;
    int hold;

    pll_bus.PllLocked = 1'b0;
    model_reset();

    // 1: held in external reset
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);

    // 2: release, lock arrives after 10 cycles
    pll_rise = 0; fg_rise = 0;
    for (int i = 1; i <= 1200; i++) begin
      cycle(1'b0, i > 10);
      if (pll_bus.PllRESETn && pll_rise == 0) pll_rise = i;
      if (pll_bus.FgRESETn && fg_rise == 0) fg_rise = i;
    end
    chk("pll_rise_at", pll_rise, 18);
    chk("fg_rise_window", {31'd0, (fg_rise >= 115 && fg_rise <= 117)}, 32'd1);

    // 3: lock loss in RUN, then recovery
    drop = 0;
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0);
      if (!pll_bus.FgRESETn && drop == 0) drop = i;
    end
    chk("fg_drop_latency", {31'd0, (drop >= 1 && drop <= 3)}, 32'd1);
    rec = 0;
    for (int i = 1; i <= 200; i++) begin
      cycle(1'b0, 1'b1);
      if (pll_bus.FgRESETn && rec == 0) rec = i;
    end
    chk("fg_recover_window", {31'd0, (rec >= 97 && rec <= 100)}, 32'd1);

    // 4: lock chatter never qualifies
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    fg_seen = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, ((i / 10) % 2) == 0);
      if (pll_bus.FgRESETn) fg_seen++;
    end
    chk("toggle_fg_seen", fg_seen, 0);

    // 5: no lock -> periodic PLL reset pulses
    lows = 0; fall1 = 0; fall2 = 0; prev_pll = pll_bus.PllRESETn;
    for (int i = 1; i <= 8300; i++) begin
      cycle(1'b0, 1'b0);
      if (!pll_bus.PllRESETn) lows++;
      if (prev_pll && !pll_bus.PllRESETn) begin
        if (fall1 == 0) fall1 = i; else if (fall2 == 0) fall2 = i;
      end
      prev_pll = pll_bus.PllRESETn;
    end
    chk("pll_low_cycles", lows, 32);
    chk("pll_pulse_period", fall2 - fall1, TMO + PLL_RST);

    // 6: external reset during DELAY and during RUN
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 150; i++) cycle(1'b0, 1'b1);
    chk("run_before_ext", {31'd0, pll_bus.FgRESETn}, 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    fg_rise = 0;
    for (int i = 1; i <= 150; i++) begin
      cycle(1'b0, 1'b1);
      if (pll_bus.FgRESETn && fg_rise == 0) fg_rise = i;
    end
    chk("restart_fg_window", {31'd0, (fg_rise >= 115 && fg_rise <= 117)}, 32'd1);

    // 7: random lock activity with occasional external reset pulses
    hold = 0; lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        lk = $urandom_range(0, 1) == 1;
        hold = $urandom_range(1, 150);
      end
      hold--;
      cycle($urandom_range(0, 399) == 0, lk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
